// File: rtl/alu_seq_unit.sv
// Handshaked multi-cycle ALU responder: one op per request, result held until taken.
// Define ALU_MUL_EN to build func 8 as an iterative shift-add multiplier; otherwise func 8 is illegal.
module alu_seq_unit #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   func,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         carry,
    output logic         zero,
    output logic         err
);

    // Handshake: a transfer happens on a clk edge where valid && ready are both high.
    // Requests are taken only in IDLE; the result is offered only in DONE, and
    // out/carry/zero/err hold steady until the consumer's out_ready completes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic         accept;
    logic         load_alu;
    logic [W:0]   sum;
    logic [W:0]   diff;
    logic [W-1:0] alu_out;
    logic         alu_carry;
    logic         alu_err;

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign load_alu  = accept && (state_next == DONE);

    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        case (func)
            4'd0: begin alu_out = sum[W-1:0];  alu_carry = sum[W];  end
            4'd1: begin alu_out = diff[W-1:0]; alu_carry = diff[W]; end
            4'd2: alu_out = a & b;
            4'd3: alu_out = a | b;
            4'd4: alu_out = a ^ b;
            4'd5: alu_out = ~a;
            4'd6: begin alu_out = {a[W-2:0], 1'b0}; alu_carry = a[W-1]; end
            4'd7: begin alu_out = {1'b0, a[W-1:1]}; alu_carry = a[0];   end
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           mul_done;

    assign mul_done = (state == MUL) && (cnt == CW'(W));

    // One multiplier bit per cycle, LSB first; the extra cycle after the last
    // iteration registers the product into the result flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (state == MUL && !mul_done) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    state_next = (func == 4'd8) ? MUL : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef ALU_MUL_EN
            MUL:  if (mul_done) state_next = DONE;
`endif
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out   <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
            err   <= 1'b0;
        end else if (load_alu) begin
            out   <= alu_out;
            carry <= alu_carry;
            zero  <= (alu_out == '0);
            err   <= alu_err;
        end
`ifdef ALU_MUL_EN
        else if (mul_done) begin
            out   <= acc[W-1:0];
            carry <= |acc[2*W-1:W];
            zero  <= (acc[W-1:0] == '0);
            err   <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (W = 4): directed plan cases plus random ops against a arithmetic model.
// Follows ALU_MUL_EN the same way the design does.
module tb_alu_seq_unit;

    localparam int W = 4;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   func;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         carry;
    logic         zero;
    logic         err;

    int n_checks = 0;
    int n_pass   = 0;

    // expected {err, zero, carry, out} per accepted request
    logic [W+2:0] exp_q[$];

    alu_seq_unit #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W+2:0] model(input int ua, input int ub, input int uf);
        int m = 1 << W;
        int o = 0;
        int c = 0;
        int e = 0;
        case (uf)
            0: begin o = (ua + ub) % m; c = (ua + ub >= m) ? 1 : 0; end
            1: begin o = (ua - ub + m) % m; c = (ua < ub) ? 1 : 0; end
            2: o = ua & ub;
            3: o = ua | ub;
            4: o = ua ^ ub;
            5: o = m - 1 - ua;
            6: begin o = (ua * 2) % m; c = (ua >= m / 2) ? 1 : 0; end
            7: begin o = ua / 2; c = ua % 2; end
            8: begin
                if (MUL_EN) begin
                    o = (ua * ub) % m;
                    c = (ua * ub >= m) ? 1 : 0;
                end else e = 1;
            end
            default: e = 1;
        endcase
        return {e[0], (o == 0), c[0], o[W-1:0]};
    endfunction

    function automatic int latency(input int uf);
        return (uf == 8 && MUL_EN) ? W + 1 : 1;
    endfunction

    task automatic wait_ready();
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", in_ready, 1);
    endtask

    // Issue one op, scramble operands and keep a stray request up while busy,
    // hold the result for 'hold' extra cycles, then take it.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [3:0] tf,
                          input int hold);
        int lat;
        logic [W+2:0] exp;
        wait_ready();
        a = ta; b = tb; func = tf; in_valid = 1'b1;
        exp_q.push_back(model(ta, tb, tf));
        @(posedge clk);
        #1;
        a = W'($urandom); b = W'($urandom); func = 4'($urandom); in_valid = 1'b1;
        @(negedge clk);
        check("busy_ready", in_ready, 0);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        check("latency", lat, latency(tf));
        exp = exp_q.pop_front();
        check("out",   out,   exp[W-1:0]);
        check("carry", carry, exp[W]);
        check("zero",  zero,  exp[W+1]);
        check("err",   err,   exp[W+2]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_result", {err, zero, carry, out}, exp);
            check("hold_valid",  out_valid, 1);
            check("hold_ready",  in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("taken_valid", out_valid, 0);
        check("taken_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; func = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready, 0);
        check("rst_result",    {err, zero, carry, out}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);

        run_op(4'hF, 4'h1, 4'd0, 0);
        run_op(4'd3, 4'd5, 4'd1, 1);
        run_op(4'b1010, 4'd0, 4'd6, 0);
        run_op(4'd3, 4'd5, 4'd8, 0);
        run_op(4'd4, 4'd4, 4'd8, 3);
        run_op(4'hF, 4'hF, 4'd8, 2);
        run_op(4'd9, 4'd0, 4'd8, 0);
        run_op(4'd5, 4'd7, 4'd12, 3);
        run_op(4'd1, 4'd0, 4'd7, 0);

        // abandon an op two edges after accept (mid-multiply, or DONE without the multiplier)
        wait_ready();
        a = 4'd7; b = 4'd9; func = MUL_EN ? 4'd8 : 4'd0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_valid",  out_valid, 0);
        check("midrst_ready",  in_ready, 0);
        check("midrst_result", {err, zero, carry, out}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", in_ready, 1);
        check("midrst_no_result",   out_valid, 0);
        run_op(4'd9, 4'd6, 4'd0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
